// File: rtl/me_scan_ctrl.sv
// me_scan_ctrl: sequencing controller for a BLK x BLK motion-estimation PE array.
// It loads the current block and the first search-window rows, walks all SR x SR
// search positions in column-snake order, and keeps the minimum SAD with its
// motion vector.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 begin one search (accepted only while idle)
//   busy, done            run in progress / one-cycle result-valid pulse
//   sel                   PE step: 00 dy+1, 01 dy-1, 10 dx+1, 11 idle/flush
//   cur_rd, cur_row       current-block row read and its index
//   sw_rd, sw_edge        search-window edge fetch; edge 0 = row, 1 = column
//   sw_addr_x, sw_addr_y  start coordinate of the fetched edge
//   sad_in                adder-tree SAD, valid SAD_LAT cycles after evaluation
//   best_sad, best_mvx/y  running minimum SAD and its signed motion vector
module me_scan_ctrl #(
    parameter int PIXWIDTH = 8,
    parameter int BLK      = 4,
    parameter int SR       = 8,
    parameter int SAD_LAT  = 2,
    parameter int SADW     = PIXWIDTH + 2 * $clog2(BLK),
    parameter int MVW      = $clog2(SR) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    sel,
    output logic                          cur_rd,
    output logic [$clog2(BLK)-1:0]        cur_row,
    output logic                          sw_rd,
    output logic                          sw_edge,
    output logic [$clog2(SR+BLK)-1:0]     sw_addr_x,
    output logic [$clog2(SR+BLK)-1:0]     sw_addr_y,
    input  logic [SADW-1:0]               sad_in,
    output logic [SADW-1:0]               best_sad,
    output logic signed [MVW-1:0]         best_mvx,
    output logic signed [MVW-1:0]         best_mvy
);

    localparam int RW = $clog2(BLK);
    localparam int XW = $clog2(SR);
    localparam int AW = $clog2(SR + BLK);
    localparam int DW = $clog2(SAD_LAT + 1);
    localparam logic [XW-1:0] LAST = XW'(SR - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DRAIN} state_t;
    typedef enum logic [1:0] {
        STEP_DN   = 2'b00,
        STEP_UP   = 2'b01,
        STEP_RT   = 2'b10,
        STEP_NONE = 2'b11
    } step_t;

    // Move from (x,y) to the next position of the column snake.
    function automatic step_t step_of(input logic [XW-1:0] x, input logic [XW-1:0] y);
        if (!x[0] && y != LAST)  return STEP_DN;
        else if (x[0] && y != '0) return STEP_UP;
        else if (x != LAST)       return STEP_RT;
        else                      return STEP_NONE;
    endfunction

    state_t          state_q, state_d;
    logic [RW-1:0]   k_q, k_d;
    logic [XW-1:0]   dx_q, dx_d, dy_q, dy_d;
    logic [DW-1:0]   dc_q, dc_d;
    step_t           step_nxt;

    logic            busy_d, done_d, cur_rd_d, sw_rd_d, sw_edge_d;
    logic [1:0]      sel_d;
    logic [RW-1:0]   cur_row_d;
    logic [AW-1:0]   ax_d, ay_d;

    // Evaluated positions travel alongside the adder-tree latency.
    logic            pv_q [SAD_LAT];
    logic [XW-1:0]   px_q [SAD_LAT];
    logic [XW-1:0]   py_q [SAD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            dc_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            dc_q    <= dc_d;
        end
    end

    // Next-state, then outputs derived from the next state so that every
    // output can be registered while still lining up with its cycle.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        dc_d      = dc_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                k_d     = '0;
            end
            LOAD: if (k_q == RW'(BLK - 1)) begin
                state_d = SCAN;
                dx_d    = '0;
                dy_d    = '0;
            end else begin
                k_d = k_q + RW'(1);
            end
            SCAN: unique case (step_of(dx_q, dy_q))
                STEP_DN: dy_d = dy_q + XW'(1);
                STEP_UP: dy_d = dy_q - XW'(1);
                STEP_RT: dx_d = dx_q + XW'(1);
                default: begin
                    state_d = DRAIN;
                    dc_d    = '0;
                end
            endcase
            DRAIN: if (dc_q == DW'(SAD_LAT)) state_d = IDLE;
                   else                       dc_d    = dc_q + DW'(1);
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DRAIN) && (dc_d == DW'(SAD_LAT));
        sel_d     = 2'b11;
        cur_rd_d  = 1'b0;
        cur_row_d = '0;
        sw_rd_d   = 1'b0;
        sw_edge_d = 1'b0;
        ax_d      = '0;
        ay_d      = '0;
        step_nxt  = step_of(dx_d, dy_d);
        if (state_d == LOAD) begin
            cur_rd_d  = 1'b1;
            cur_row_d = k_d;
            sel_d     = 2'b00;
            sw_rd_d   = 1'b1;
            ay_d      = AW'(k_d);
        end else if (state_d == SCAN) begin
            sel_d = step_nxt;
            unique case (step_nxt)
                STEP_DN: begin
                    sw_rd_d = 1'b1;
                    ax_d    = AW'(dx_d);
                    ay_d    = AW'(dy_d) + AW'(BLK);
                end
                STEP_UP: begin
                    sw_rd_d = 1'b1;
                    ax_d    = AW'(dx_d);
                    ay_d    = AW'(dy_d) - AW'(1);
                end
                STEP_RT: begin
                    sw_rd_d   = 1'b1;
                    sw_edge_d = 1'b1;
                    ax_d      = AW'(dx_d) + AW'(BLK);
                    ay_d      = AW'(dy_d);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            sel       <= 2'b11;
            cur_rd    <= 1'b0;
            cur_row   <= '0;
            sw_rd     <= 1'b0;
            sw_edge   <= 1'b0;
            sw_addr_x <= '0;
            sw_addr_y <= '0;
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            sel       <= sel_d;
            cur_rd    <= cur_rd_d;
            cur_row   <= cur_row_d;
            sw_rd     <= sw_rd_d;
            sw_edge   <= sw_edge_d;
            sw_addr_x <= ax_d;
            sw_addr_y <= ay_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SAD_LAT; i++) begin
                pv_q[i] <= 1'b0;
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= (state_q == SCAN);
            px_q[0] <= dx_q;
            py_q[0] <= dy_q;
            for (int unsigned i = 1; i < SAD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                px_q[i] <= px_q[i-1];
                py_q[i] <= py_q[i-1];
            end
        end
    end

    // Strict less-than keeps the earliest snake position on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_sad <= '1;
            best_mvx <= '0;
            best_mvy <= '0;
        end else if (state_q == IDLE && start) begin
            best_sad <= '1;
        end else if (pv_q[SAD_LAT-1] && sad_in < best_sad) begin
            best_sad <= sad_in;
            best_mvx <= MVW'(px_q[SAD_LAT-1]) - MVW'(SR / 2);
            best_mvy <= MVW'(py_q[SAD_LAT-1]) - MVW'(SR / 2);
        end
    end

endmodule

// File: tb/tb_me_scan_ctrl.sv
module tb_me_scan_ctrl;

    localparam int PIXWIDTH = 8;
    localparam int BLK      = 4;
    localparam int SR       = 8;
    localparam int SAD_LAT  = 2;
    localparam int SADW     = PIXWIDTH + 2 * $clog2(BLK);
    localparam int MVW      = $clog2(SR) + 1;
    localparam int RW       = $clog2(BLK);
    localparam int AW       = $clog2(SR + BLK);
    localparam int NPOS     = SR * SR;
    localparam int R        = SR / 2;
    localparam int DONE_R   = BLK + NPOS + SAD_LAT + 1;
    localparam int ONES     = (1 << SADW) - 1;

    logic              clk, rst, start;
    logic              busy, done, cur_rd, sw_rd, sw_edge;
    logic [1:0]        sel;
    logic [RW-1:0]     cur_row;
    logic [AW-1:0]     sw_addr_x, sw_addr_y;
    logic [SADW-1:0]   sad_in, best_sad;
    logic [MVW-1:0]    best_mvx, best_mvy;

    me_scan_ctrl #(
        .PIXWIDTH(PIXWIDTH), .BLK(BLK), .SR(SR), .SAD_LAT(SAD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .sel(sel), .cur_rd(cur_rd), .cur_row(cur_row), .sw_rd(sw_rd),
        .sw_edge(sw_edge), .sw_addr_x(sw_addr_x), .sw_addr_y(sw_addr_y),
        .sad_in(sad_in), .best_sad(best_sad), .best_mvx(best_mvx),
        .best_mvy(best_mvy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pcnt = 0;
    always @(posedge clk) pcnt <= pcnt + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, $signed(got), $signed(exp), pcnt);
        end
    endtask

    function automatic int sx(input logic [MVW-1:0] v);
        return int'($signed(v));
    endfunction

    // Snake order: even columns walk down, odd columns walk up.
    function automatic int pdx(input int p);
        return p / SR;
    endfunction
    function automatic int pdy(input int p);
        return ((p / SR) % 2 == 0) ? (p % SR) : (SR - 1 - p % SR);
    endfunction
    function automatic int idx(input int x, input int y);
        return x * SR + ((x % 2 == 0) ? y : (SR - 1 - y));
    endfunction

    // Reference model state: t0 is the cycle in which an accepted start was high.
    int       t0 = -1000000;
    int       m_best = ONES;
    int       m_mvx = 0;
    int       m_mvy = 0;
    logic     start_prev = 1'b0;
    int       sad_prev = 0;
    int       ncyc = 0;
    int       rst_count = 0;
    int       last_rst = 0;
    int       sad_tab [NPOS];

    function automatic bit busy_at(input int c);
        int r;
        r = c - t0;
        return (r >= 1 && r <= DONE_R);
    endfunction

    always @(negedge clk) begin : compare
        int r, p, x, y, nx, ny;
        int e_sel, e_cur, e_row, e_sw, e_edge, e_x, e_y;
        ncyc++;
        r = ncyc - 1 - t0;
        p = r - BLK - 1 - SAD_LAT;
        if (p >= 0 && p < NPOS && sad_prev < m_best) begin
            m_best = sad_prev;
            m_mvx  = pdx(p) - R;
            m_mvy  = pdy(p) - R;
        end
        if (start_prev && !busy_at(ncyc - 1)) begin
            t0     = ncyc - 1;
            m_best = ONES;
        end
        if (rst || rst_count != last_rst) begin
            t0       = -1000000;
            m_best   = ONES;
            m_mvx    = 0;
            m_mvy    = 0;
            last_rst = rst_count;
        end
        r = ncyc - t0;
        e_sel = 3; e_cur = 0; e_row = 0; e_sw = 0; e_edge = 0; e_x = 0; e_y = 0;
        if (r >= 1 && r <= BLK) begin
            e_sel = 0; e_cur = 1; e_row = r - 1; e_sw = 1; e_y = r - 1;
        end else if (r > BLK && r <= BLK + NPOS) begin
            p = r - BLK - 1;
            if (p < NPOS - 1) begin
                x = pdx(p); y = pdy(p); nx = pdx(p + 1); ny = pdy(p + 1);
                e_sw = 1;
                if (nx != x) begin
                    e_sel = 2; e_edge = 1; e_x = x + BLK; e_y = y;
                end else if (ny > y) begin
                    e_sel = 0; e_x = x; e_y = y + BLK;
                end else begin
                    e_sel = 1; e_x = x; e_y = y - 1;
                end
            end
        end
        chk("busy", busy, (r >= 1 && r <= DONE_R) ? 1 : 0);
        chk("done", done, (r == DONE_R) ? 1 : 0);
        chk("sel", sel, e_sel);
        chk("cur_rd", cur_rd, e_cur);
        chk("sw_rd", sw_rd, e_sw);
        chk("best_sad", best_sad, m_best);
        chk("best_mvx", sx(best_mvx), m_mvx);
        chk("best_mvy", sx(best_mvy), m_mvy);
        if (e_cur != 0) chk("cur_row", cur_row, e_row);
        if (e_sw != 0) begin
            chk("sw_edge", sw_edge, e_edge);
            chk("sw_addr_x", sw_addr_x, e_x);
            chk("sw_addr_y", sw_addr_y, e_y);
        end
        start_prev = start;
        sad_prev   = int'(sad_in);
    end

    // SAD source: table value in each position's sample cycle, junk otherwise.
    always @(posedge clk) begin : sad_drive
        int p;
        #1;
        p = pcnt - t0 - BLK - 1 - SAD_LAT;
        if (p >= 0 && p < NPOS) sad_in = SADW'(sad_tab[p]);
        else                    sad_in = SADW'($urandom_range(0, 3));
    end

    task automatic at_cycle(input int c);
        while (pcnt < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic launch(output int l);
        start = 1'b1;
        l = pcnt;
        at_cycle(l + 1);
        start = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        rst_count++;
        #1;
        chk("rst_sel", sel, 3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cur_rd", cur_rd, 0);
        chk("rst_sw_rd", sw_rd, 0);
        chk("rst_cur_row", cur_row, 0);
        chk("rst_addr_x", sw_addr_x, 0);
        chk("rst_addr_y", sw_addr_y, 0);
        chk("rst_best_sad", best_sad, ONES);
        chk("rst_mvx", sx(best_mvx), 0);
        chk("rst_mvy", sx(best_mvy), 0);
        #1;
        rst = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPOS; i++) sad_tab[i] = $urandom_range(5, 300);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        int l, l2, mn;
        rst = 1'b1;
        start = 1'b0;
        sad_in = '0;
        for (int i = 0; i < NPOS; i++) sad_tab[i] = 100;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        at_cycle(5);

        // Abort in the middle of LOAD.
        fill_random();
        launch(l);
        at_cycle(l + 2);
        chk("loadA_cur_rd", cur_rd, 1);
        do_rst();
        at_cycle(pcnt + 2);

        // Unique minimum at (5,2), sel sequence and fetch addressing.
        for (int i = 0; i < NPOS; i++) sad_tab[i] = 100;
        sad_tab[idx(5, 2)] = 7;
        launch(l);
        at_cycle(l + 1);
        chk("B1_sel", sel, 0);
        chk("B1_busy", busy, 1);
        chk("B1_cur_rd", cur_rd, 1);
        at_cycle(l + 12);
        chk("B12_sel", sel, 2);
        at_cycle(l + 13);
        chk("B13_sel", sel, 1);
        at_cycle(l + 15);
        chk("B15_sel", sel, 1);
        chk("B15_edge", sw_edge, 0);
        chk("B15_x", sw_addr_x, 1);
        chk("B15_y", sw_addr_y, 4);
        at_cycle(l + 28);
        chk("B28_sel", sel, 2);
        chk("B28_edge", sw_edge, 1);
        chk("B28_x", sw_addr_x, 6);
        chk("B28_y", sw_addr_y, 7);
        at_cycle(l + 68);
        chk("B68_sel", sel, 3);
        chk("B68_sw_rd", sw_rd, 0);
        at_cycle(l + 70);
        chk("B70_done", done, 0);
        at_cycle(l + 71);
        chk("B71_done", done, 1);
        chk("B71_busy", busy, 1);
        chk("B71_best", best_sad, 7);
        chk("B71_mvx", sx(best_mvx), 1);
        chk("B71_mvy", sx(best_mvy), -2);
        at_cycle(l + 72);
        chk("B72_done", done, 0);
        chk("B72_busy", busy, 0);
        chk("B72_hold", best_sad, 7);
        at_cycle(l + 74);

        // Tie at (0,0) and (3,3); start pulsed mid-run is ignored.
        for (int i = 0; i < NPOS; i++) sad_tab[i] = 50;
        sad_tab[idx(0, 0)] = 0;
        sad_tab[idx(3, 3)] = 0;
        launch(l);
        at_cycle(l + 30);
        start = 1'b1;
        at_cycle(l + 31);
        start = 1'b0;
        at_cycle(l + 71);
        chk("C71_done", done, 1);
        chk("C71_best", best_sad, 0);
        chk("C71_mvx", sx(best_mvx), -4);
        chk("C71_mvy", sx(best_mvy), -4);

        // Start in the cycle right after done, then reset mid-SCAN.
        at_cycle(l + 72);
        fill_random();
        launch(l2);
        chk("D_launch", l2, l + 72);
        chk("D1_busy", busy, 1);
        at_cycle(l2 + 40);
        do_rst();
        at_cycle(pcnt + 2);

        // Full random run after the reset.
        fill_random();
        mn = ONES;
        for (int i = 0; i < NPOS; i++) if (sad_tab[i] < mn) mn = sad_tab[i];
        launch(l);
        at_cycle(l + 70);
        chk("E70_done", done, 0);
        at_cycle(l + 71);
        chk("E71_done", done, 1);
        chk("E71_best", best_sad, mn);
        at_cycle(l + 72);
        chk("E72_busy", busy, 0);
        at_cycle(l + 75);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
